mux_stim_gen: RTL and testbench
===============================

Name: mux_stim_gen

Overview:
Programmable stimulus sequencer that sits directly upstream of the 2:1 mux (`mux`). It drives the mux's `a`, `b` and `sel` inputs as square waves whose periods are divided by 1, 2 and 4 (defaults).
- Runs a bounded burst on a start/done handshake.
- Usable in the tb and in on-board self-test.
- Optionally checks the mux output against the expected value.

Parameters:
- TICK_DIV, 1: clock cycles per tick; must be ≥1.
- A_DIV, 1: ticks per toggle of `a`.
- B_DIV, 2: ticks per toggle of `b`.
- SEL_DIV, 4: ticks per toggle of `sel`.
- RUN_TICKS, 24: ticks per burst; range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin burst; sampled only in IDLE.
- abort  in  1  synchronous abort of a running burst.
- a  out  1  mux data input 0.
- b  out  1  mux data input 1.
- sel  out  1  mux select; 1 selects `b`.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at burst end.
- x_in  in  1  mux output; present only with MUX_STIM_CHECK_EN.
- err_cnt  out  8  mismatch count; present only with MUX_STIM_CHECK_EN.

Behaviour:
Reset and output registration:
- Single clock domain; reset is asynchronous and active-high.
- On reset: state=IDLE; a, b, sel, busy, done = 0; all counters = 0; err_cnt = 0.
- Reset asserted mid-burst forces IDLE immediately. No done pulse is produced.
- All outputs are registered; no combinational path from input to output.

State machine (IDLE, RUN, DONE):
- IDLE → RUN on the edge sampling start=1. Clears the prescaler, divider and tick counters. a, b, sel stay 0.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. `tick` is high in the cycle where the count equals TICK_DIV-1, then the count wraps to 0.
  - With TICK_DIV=1, tick is high every RUN cycle.
- Per tick, for each output (`a`, `b`, `sel`):
  - Its divider counter increments.
  - When the counter equals DIV-1, the output toggles on that edge and the counter wraps to 0.
- Tick counter (16 bit):
  - Increments per tick.
  - On the tick where it equals RUN_TICKS-1, state goes to DONE on that edge. The output toggles due on that tick still take effect.
- abort=1 in RUN → IDLE next edge. a, b, sel cleared; no done. abort has priority over tick and over burst end in the same cycle.
- DONE lasts one cycle: done=1, busy=0, outputs hold their final values. Then → IDLE, where a, b, sel clear to 0.
- start outside IDLE is ignored. abort outside RUN is ignored.
- Timing with TICK_DIV=1:
  - The first toggle of `a` is visible 1 cycle after the RUN-entry edge.
  - done is high 24 edges after the edge that sampled start.

Optional Feature:
Macro: MUX_STIM_CHECK_EN.
- Defined:
  - Ports `x_in` and `err_cnt` exist.
  - In every RUN cycle the block compares x_in with (sel ? b : a), using the registered outputs of that same cycle.
  - Each mismatch increments err_cnt, which saturates at 255.
  - err_cnt clears on the IDLE→RUN edge and holds through DONE and IDLE.
- Undefined: `x_in` and `err_cnt` ports and all checker logic are absent. The other ports and behaviour are identical.

Decomposition:
- Shared package `mux_stim_pkg`:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Tick counter width constant TCNT_W=16.
  - err_cnt width ERR_W=8.
- One sub-module, `toggle_div`:
  - Parameter DIV; inputs clk, rst, clr, tick; output q.
  - Counter plus toggle flop.
  - Instantiated three times, for a, b and sel.

Test Plan:
- Defaults; pulse start for 1 cycle → at ticks 1, 2, 3, 4: a=1,0,1,0; b=0,1,1,0; sel=0,0,0,1. busy=1 for 24 cycles; done=1 for exactly one cycle; then a=b=sel=0.
- TICK_DIV=3 → `a` toggles every 3 cycles, `b` every 6, `sel` every 12. done occurs 72 edges after the start-sampling edge.
- abort asserted at tick 10 → next edge IDLE; busy=0, done never pulses, outputs 0. A new start restarts from a=b=sel=0.
- rst asserted mid-RUN (tick 5), with no clock edge → outputs and busy drop to 0 immediately. After release, the block stays IDLE until start.
- start held high through RUN and DONE → exactly one burst per IDLE entry; the second burst begins the edge after returning to IDLE.
- MUX_STIM_CHECK_EN with a correct mux → err_cnt=0 at done. With x_in forced to 0, err_cnt equals the number of RUN cycles where sel?b:a = 1 (12 for defaults).

Source files
------------

// File: rtl/mux_stim_pkg.sv
// Shared types and widths for the mux stimulus generator and its toggle dividers.
package mux_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TCNT_W = 16;
  localparam int ERR_W  = 8;

  // Counter width for a modulo-n count; a 1-bit counter covers n = 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_stim_gen_toggle_div.sv
// Tick-driven square-wave divider: toggles q every DIV ticks; clr has priority over tick.
module toggle_div
  import mux_stim_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic q
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    if (clr) begin
      cnt_d = '0;
      q_d   = 1'b0;
    end else if (tick) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        q_d   = ~q_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mux_stim_gen.sv
// Burst stimulus sequencer driving a 2:1 mux (a, b, sel) on a start/done handshake.
// Define MUX_STIM_CHECK_EN to add the x_in/err_cnt output checker.
//
// state | meaning
// IDLE  | waiting for start; a, b, sel held at 0
// RUN   | prescaler and dividers active, busy = 1
// DONE  | one cycle, done = 1, outputs hold their final values
module mux_stim_gen
  import mux_stim_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int A_DIV     = 1,
  parameter int B_DIV     = 2,
  parameter int SEL_DIV   = 4,
  parameter int RUN_TICKS = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
`ifdef MUX_STIM_CHECK_EN
  input  logic             x_in,
  output logic [ERR_W-1:0] err_cnt,
`endif
  output logic             a,
  output logic             b,
  output logic             sel,
  output logic             busy,
  output logic             done
);

  localparam int                PW         = cnt_width(TICK_DIV);
  localparam logic [PW-1:0]     PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(RUN_TICKS - 1);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [PW-1:0]     pre_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic              tick, clr;
  logic              a_q, b_q, sel_q;

  // abort wins over tick, so a same-cycle burst end is swallowed.
  assign tick = (state_q == RUN) && !abort && (pre_q == PRE_LAST);
  // Dividers run only in RUN; clearing while in DONE zeroes them on the way back to IDLE.
  assign clr  = (state_q != RUN) || abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            pre_q   <= '0;
            tcnt_q  <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            tcnt_q  <= '0;
          end else if (tick) begin
            pre_q <= '0;
            if (tcnt_q == TCNT_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tcnt_q  <= '0;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  toggle_div #(.DIV(A_DIV)) u_div_a (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick),
    .q    (a_q)
  );

  toggle_div #(.DIV(B_DIV)) u_div_b (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick),
    .q    (b_q)
  );

  toggle_div #(.DIV(SEL_DIV)) u_div_sel (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick),
    .q    (sel_q)
  );

  assign a    = a_q;
  assign b    = b_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef MUX_STIM_CHECK_EN
  logic [ERR_W-1:0] err_q;

  // Compares against the registered stimulus of the same cycle; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      err_q <= '0;
    end else if ((state_q == RUN) && (x_in != (sel_q ? b_q : a_q)) && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_mux_stim_gen.sv
// Self-checking bench for mux_stim_gen: default instance plus a TICK_DIV=3 instance.
module tb_mux_stim_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic start3 = 1'b0, abort3 = 1'b0;
  logic a, b, sel, busy, done;
  logic a3, b3, sel3, busy3, done3;

  int tests = 0;
  int fails = 0;

  logic [4:0] exp_q[$];
`ifdef MUX_STIM_CHECK_EN
  logic       x_mode = 1'b0;
  logic       x_in, x_in3;
  logic [7:0] err_cnt, err_cnt3;
  logic [7:0] err_exp_q[$];
  assign x_in  = x_mode ? 1'b0 : (sel ? b : a);
  assign x_in3 = sel3 ? b3 : a3;
`endif

  always #5 clk = ~clk;

  mux_stim_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
`ifdef MUX_STIM_CHECK_EN
    .x_in    (x_in),
    .err_cnt (err_cnt),
`endif
    .a       (a),
    .b       (b),
    .sel     (sel),
    .busy    (busy),
    .done    (done)
  );

  mux_stim_gen #(.TICK_DIV(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .start   (start3),
    .abort   (abort3),
`ifdef MUX_STIM_CHECK_EN
    .x_in    (x_in3),
    .err_cnt (err_cnt3),
`endif
    .a       (a3),
    .b       (b3),
    .sel     (sel3),
    .busy    (busy3),
    .done    (done3)
  );

  // Expected {a,b,sel,busy,done} k cycles after the edge that sampled start (defaults DIVs).
  function automatic logic [4:0] model(input int td, input int k);
    int t;
    if (k > 24 * td) return 5'b0;
    t = k / td;
    return {((t % 2) == 1), ((t % 4) >= 2), ((t % 8) >= 4), (k < 24 * td), (k == 24 * td)};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({a, b, sel, busy, done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_default: got %b expected %b", {a, b, sel, busy, done}, 5'b0);
    end
    tests++;
    if ({a3, b3, sel3, busy3, done3} !== 5'b0) begin
      fails++;
      $display("FAIL reset_div3: got %b expected %b", {a3, b3, sel3, busy3, done3}, 5'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    logic [4:0] e;
    int k = 0;
    for (int i = 0; i <= 26; i++) exp_q.push_back(model(1, i));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({a, b, sel, busy, done} !== e) begin
        fails++;
        $display("FAIL burst k=%0d: got %b expected %b", k, {a, b, sel, busy, done}, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_tick_div3();
    logic [4:0] e;
    int k = 0;
    for (int i = 0; i <= 74; i++) exp_q.push_back(model(3, i));
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({a3, b3, sel3, busy3, done3} !== e) begin
        fails++;
        $display("FAIL tick_div3 k=%0d: got %b expected %b", k, {a3, b3, sel3, busy3, done3}, e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    logic [4:0] e;
    int k = 0;
    for (int i = 0; i <= 10; i++) exp_q.push_back(model(1, i));
    for (int i = 0; i < 5; i++) exp_q.push_back(5'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({a, b, sel, busy, done} !== e) begin
        fails++;
        $display("FAIL abort k=%0d: got %b expected %b", k, {a, b, sel, busy, done}, e);
      end
      @(posedge clk); #1;
      abort = (k == 9);
      k++;
    end
    abort = 1'b0;
    test_burst();
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] e;
    for (int i = 0; i <= 5; i++) exp_q.push_back(model(1, i));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({a, b, sel, busy, done} !== e) begin
        fails++;
        $display("FAIL pre_reset k=%0d: got %b expected %b", k, {a, b, sel, busy, done}, e);
      end
      if (k < 5) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({a, b, sel, busy, done} !== 5'b0) begin
      fails++;
      $display("FAIL async_reset: got %b expected %b", {a, b, sel, busy, done}, 5'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(5'b0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({a, b, sel, busy, done} !== e) begin
        fails++;
        $display("FAIL post_reset_idle: got %b expected %b", {a, b, sel, busy, done}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_held();
    logic [4:0] e;
    int j = 0;
    for (int i = 0; i <= 24; i++) exp_q.push_back(model(1, i));
    exp_q.push_back(5'b0);
    for (int i = 0; i <= 26; i++) exp_q.push_back(model(1, i));
    start = 1'b1;
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({a, b, sel, busy, done} !== e) begin
        fails++;
        $display("FAIL start_held j=%0d: got %b expected %b", j, {a, b, sel, busy, done}, e);
      end
      @(posedge clk); #1;
      if (j == 26) start = 1'b0;
      j++;
    end
    start = 1'b0;
  endtask

`ifdef MUX_STIM_CHECK_EN
  task automatic run_checker(input logic force_zero);
    logic [4:0] m;
    logic [7:0] e;
    int cum = 0;
    x_mode = force_zero;
    for (int k = 0; k <= 27; k++) begin
      err_exp_q.push_back(8'(cum));
      if (k < 24) begin
        m = model(1, k);
        if (force_zero && (m[2] ? m[3] : m[4])) cum++;
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      e = err_exp_q.pop_front();
      tests++;
      if (err_cnt !== e) begin
        fails++;
        $display("FAIL err_cnt zero=%0b k=%0d: got %0d expected %0d", force_zero, k, err_cnt, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_checker();
    run_checker(1'b1);
    run_checker(1'b0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_burst();
    test_tick_div3();
    test_abort();
    test_reset_mid_run();
    test_start_held();
`ifdef MUX_STIM_CHECK_EN
    test_checker();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
